// File: rtl/host_up_arbiter_if.sv
`timescale 1ns/1ps
// Requester-side and HostIoComm-side signals of the upstream write arbiter.
// The arbiter takes the slave view; sources and the FIFO side take the master view.
interface host_up_arbiter_if #(
    parameter int NUM_REQ_G    = 4,
    parameter int DATA_WIDTH_G = 8
);
    logic [NUM_REQ_G-1:0]              req_valid_i;
    logic [NUM_REQ_G*DATA_WIDTH_G-1:0] req_data_i;
    logic [NUM_REQ_G-1:0]              req_last_i;
    logic [NUM_REQ_G-1:0]              req_ready_o;
    logic [NUM_REQ_G-1:0]              grant_o;
    logic                              add_o;
    logic [DATA_WIDTH_G-1:0]           data_o;
    logic                              upFull_i;
    logic                              busy_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, upFull_i,
        output req_ready_o, grant_o, add_o, data_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, upFull_i,
        input  req_ready_o, grant_o, add_o, data_o, busy_o
    );
endinterface

// File: rtl/host_up_arbiter.sv
`timescale 1ns/1ps
// Round-robin, packet-locked arbiter onto the HostIoComm upstream FIFO write port.
// Every accepted beat is followed by one dead cycle so upFull can settle.
module host_up_arbiter #(
    parameter int NUM_REQ_G    = 4,
    parameter int DATA_WIDTH_G = 8,
    parameter int MAX_BURST_G  = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    host_up_arbiter_if.slave bus
);
    // state  | meaning
    // IDLE   | no owner; next requester chosen round-robin
    // XFER   | owner holds grant; at most one beat transfers
    // SETTLE | add_o pulses; release grant or go back to XFER

    localparam int IDX_W = (NUM_REQ_G > 1) ? $clog2(NUM_REQ_G) : 1;
    localparam int CNT_W = $clog2(MAX_BURST_G + 1);

    typedef enum logic [1:0] {IDLE, XFER, SETTLE} arbStateT;

    arbStateT                state, stateNext;
    logic [NUM_REQ_G-1:0]    grantQ, grantNext;
    logic [IDX_W-1:0]        lastWin, lastWinNext, winner, ownerIdx;
    logic [CNT_W-1:0]        count, countNext, countInc;
    logic                    releaseQ, releaseNext;
    logic                    addQ, addNext;
    logic [DATA_WIDTH_G-1:0] dataQ, dataNext, ownerData;
    logic                    anyValid, ownerLast, ownerValid, beat;

    // Candidate offset from the last winner decides priority; the smallest offset wins.
    always_comb begin : pickWinner
        int bestOff;
        int offs;
        winner   = '0;
        anyValid = 1'b0;
        bestOff  = NUM_REQ_G;
        offs     = 0;
        for (int c = 0; c < NUM_REQ_G; c++) begin
            offs = (c + NUM_REQ_G - 1 - int'(lastWin)) % NUM_REQ_G;
            if (bus.req_valid_i[c] && (offs < bestOff)) begin
                bestOff  = offs;
                winner   = IDX_W'(c);
                anyValid = 1'b1;
            end
        end
    end

    always_comb begin
        ownerIdx   = '0;
        ownerData  = '0;
        ownerLast  = 1'b0;
        ownerValid = 1'b0;
        for (int c = 0; c < NUM_REQ_G; c++) begin
            if (grantQ[c]) begin
                ownerIdx   = IDX_W'(c);
                ownerData  = bus.req_data_i[c*DATA_WIDTH_G +: DATA_WIDTH_G];
                ownerLast  = bus.req_last_i[c];
                ownerValid = bus.req_valid_i[c];
            end
        end
    end

    assign beat     = (state == XFER) && ownerValid && !bus.upFull_i;
    assign countInc = count + CNT_W'(1);

    always_comb begin
        stateNext   = state;
        grantNext   = grantQ;
        lastWinNext = lastWin;
        countNext   = count;
        releaseNext = releaseQ;
        addNext     = 1'b0;
        dataNext    = dataQ;
        unique case (state)
            IDLE: begin
                if (anyValid) begin
                    for (int c = 0; c < NUM_REQ_G; c++) begin
                        grantNext[c] = (winner == IDX_W'(c));
                    end
                    countNext = '0;
                    stateNext = XFER;
                end
            end
            XFER: begin
                if (beat) begin
                    dataNext    = ownerData;
                    addNext     = 1'b1;
                    countNext   = countInc;
                    releaseNext = ownerLast || (countInc == CNT_W'(MAX_BURST_G));
                    stateNext   = SETTLE;
                end
            end
            SETTLE: begin
                if (releaseQ) begin
                    grantNext   = '0;
                    lastWinNext = ownerIdx;
                    stateNext   = IDLE;
                end else begin
                    stateNext = XFER;
                end
            end
            default: begin
                grantNext = '0;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            grantQ   <= '0;
            lastWin  <= IDX_W'(NUM_REQ_G - 1);
            count    <= '0;
            releaseQ <= 1'b0;
            addQ     <= 1'b0;
            dataQ    <= '0;
        end else begin
            state    <= stateNext;
            grantQ   <= grantNext;
            lastWin  <= lastWinNext;
            count    <= countNext;
            releaseQ <= releaseNext;
            addQ     <= addNext;
            dataQ    <= dataNext;
        end
    end

    // Ready is combinational so the owner sees upFull in the same cycle it would write.
    assign bus.req_ready_o = ((state == XFER) && !bus.upFull_i) ? (bus.req_valid_i & grantQ) : '0;
    assign bus.grant_o     = grantQ;
    assign bus.add_o       = addQ;
    assign bus.data_o      = dataQ;
    assign bus.busy_o      = (state != IDLE);
endmodule

// File: tb/tb_host_up_arbiter.sv
`timescale 1ns/1ps
// Bench for host_up_arbiter: directed scenarios plus a randomized run checked
// cycle by cycle against a transaction-level owner/cooldown model.
module tb_host_up_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 16;

    logic clk_s = 1'b0;
    logic rst_n;

    host_up_arbiter_if #(.NUM_REQ_G(N), .DATA_WIDTH_G(W)) bus ();

    host_up_arbiter #(.NUM_REQ_G(N), .DATA_WIDTH_G(W), .MAX_BURST_G(MB)) dut (
        .clk_i    (clk_s),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    always #5 clk_s = ~clk_s;

    int checks = 0;
    int errors = 0;

    logic [7:0]   dq [N][$];
    bit           lq [N][$];
    bit           gate [N];
    bit           flag [N];
    bit           fullDrive;
    int           popped;
    int           cycNum;
    logic [N-1:0] vDrv, lDrv;
    logic [N*W-1:0] dDrv;
    int           logOwner [$];
    logic [7:0]   logData [$];
    int           logCyc [$];

    function automatic int ownerOf(input logic [N-1:0] g);
        int r = -1;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic bit allEmpty();
        bit e = 1'b1;
        for (int k = 0; k < N; k++) if (dq[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic enq(input int k, input logic [7:0] b, input bit l);
        dq[k].push_back(b);
        lq[k].push_back(l);
    endtask

    // One clock of requester behaviour: pop what transferred, present the next heads.
    task automatic step();
        @(negedge clk_s);
        cycNum++;
        for (int k = 0; k < N; k++) begin
            if (flag[k] && dq[k].size() != 0) begin
                void'(dq[k].pop_front());
                void'(lq[k].pop_front());
                popped++;
            end
        end
        vDrv = '0; lDrv = '0; dDrv = '0;
        for (int k = 0; k < N; k++) begin
            if (dq[k].size() != 0 && !gate[k]) begin
                vDrv[k] = 1'b1;
                lDrv[k] = lq[k][0];
                dDrv[k*W +: W] = dq[k][0];
            end
        end
        bus.req_valid_i = vDrv;
        bus.req_last_i  = lDrv;
        bus.req_data_i  = dDrv;
        bus.upFull_i    = fullDrive;
        #1;
        for (int k = 0; k < N; k++) flag[k] = vDrv[k] & bus.req_ready_o[k];
        if (bus.add_o === 1'b1) begin
            logOwner.push_back(ownerOf(bus.grant_o));
            logData.push_back(bus.data_o);
            logCyc.push_back(cycNum);
        end
    endtask

    task automatic drain(input int maxCyc, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < maxCyc) begin
            step();
            n++;
            if (allEmpty() && bus.busy_o === 1'b0 && bus.add_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            dq[k].delete(); lq[k].delete(); gate[k] = 1'b0; flag[k] = 1'b0;
        end
        fullDrive = 1'b0;
        bus.req_valid_i = '0; bus.req_last_i = '0; bus.req_data_i = '0; bus.upFull_i = 1'b0;
        logOwner.delete(); logData.delete(); logCyc.delete();
        popped = 0; cycNum = 0;
        repeat (2) @(negedge clk_s);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid_i = '1; bus.req_last_i = '1; bus.req_data_i = '1; bus.upFull_i = 1'b0;
        repeat (3) @(negedge clk_s);
        #1;
        checks++; if (bus.grant_o !== '0) begin errors++; $display("FAIL reset_grant got %b want 0000", bus.grant_o); end
        checks++; if (bus.add_o !== 1'b0) begin errors++; $display("FAIL reset_add got %b want 0", bus.add_o); end
        checks++; if (bus.data_o !== '0) begin errors++; $display("FAIL reset_data got %h want 00", bus.data_o); end
        checks++; if (bus.req_ready_o !== '0) begin errors++; $display("FAIL reset_ready got %b want 0000", bus.req_ready_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        apply_reset();
        for (int k = 0; k < N; k++) enq(k, 8'h90 + 8'(k), 1'b1);
        step();
        checks++; if (bus.req_ready_o !== '0) begin errors++; $display("FAIL idle_ready got %b want 0000", bus.req_ready_o); end
        step();
        checks++; if (bus.grant_o !== 4'b0001) begin errors++; $display("FAIL first_grant got %b want 0001", bus.grant_o); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL first_busy got %b want 1", bus.busy_o); end
    endtask

    task automatic test_single_packet();
        logic [3:0] expG;
        logic [7:0] expD;
        apply_reset();
        enq(0, 8'h41, 1'b0); enq(0, 8'h42, 1'b0); enq(0, 8'h43, 1'b1);
        for (int i = 0; i <= 7; i++) begin
            step();
            expG = (i >= 1 && i <= 6) ? 4'b0001 : 4'b0000;
            checks++; if (bus.add_o !== (i == 2 || i == 4 || i == 6)) begin errors++; $display("FAIL single_add cyc %0d got %b", i, bus.add_o); end
            checks++; if (bus.grant_o !== expG) begin errors++; $display("FAIL single_grant cyc %0d got %b want %b", i, bus.grant_o, expG); end
            if (i >= 2) begin
                expD = (i < 4) ? 8'h41 : (i < 6) ? 8'h42 : 8'h43;
                checks++; if (bus.data_o !== expD) begin errors++; $display("FAIL single_data cyc %0d got %h want %h", i, bus.data_o, expD); end
            end
        end
    endtask

    task automatic test_round_robin();
        int         expO [5] = '{0, 1, 2, 3, 0};
        logic [7:0] expD [5] = '{8'h50, 8'h61, 8'h72, 8'h83, 8'h51};
        bit ok;
        apply_reset();
        enq(0, 8'h50, 1'b1); enq(0, 8'h51, 1'b1);
        enq(1, 8'h61, 1'b1); enq(2, 8'h72, 1'b1); enq(3, 8'h83, 1'b1);
        drain(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout queues not drained within 200 cycles"); end
        checks++; if (logData.size() != 5) begin errors++; $display("FAIL rr_count got %0d writes want 5", logData.size()); end
        for (int i = 0; i < 5 && i < logData.size(); i++) begin
            checks++; if (logOwner[i] != expO[i] || logData[i] !== expD[i]) begin
                errors++; $display("FAIL rr_order %0d got req%0d/%h want req%0d/%h", i, logOwner[i], logData[i], expO[i], expD[i]);
            end
            if (i > 0) begin
                checks++; if (logCyc[i] - logCyc[i-1] < 2) begin errors++; $display("FAIL rr_gap %0d got %0d cycles want >=2", i, logCyc[i] - logCyc[i-1]); end
            end
        end
    endtask

    task automatic test_burst_limit();
        int         expO [$];
        logic [7:0] expD [$];
        bit ok;
        apply_reset();
        for (int i = 0; i < 20; i++) enq(1, 8'h10 + 8'(i), i == 19);
        enq(2, 8'hA0, 1'b1);
        for (int i = 0; i < 16; i++) begin expO.push_back(1); expD.push_back(8'h10 + 8'(i)); end
        expO.push_back(2); expD.push_back(8'hA0);
        for (int i = 16; i < 20; i++) begin expO.push_back(1); expD.push_back(8'h10 + 8'(i)); end
        drain(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_timeout queues not drained within 400 cycles"); end
        checks++; if (logData.size() != 21) begin errors++; $display("FAIL burst_count got %0d writes want 21", logData.size()); end
        for (int i = 0; i < 21 && i < logData.size(); i++) begin
            checks++; if (logOwner[i] != expO[i] || logData[i] !== expD[i]) begin
                errors++; $display("FAIL burst_order %0d got req%0d/%h want req%0d/%h", i, logOwner[i], logData[i], expO[i], expD[i]);
            end
        end
    endtask

    task automatic test_upfull();
        int n = 0;
        bit ok;
        apply_reset();
        fullDrive = 1'b1;
        enq(0, 8'h31, 1'b0); enq(0, 8'h32, 1'b0); enq(0, 8'h33, 1'b1);
        while (n < 10 && bus.grant_o !== 4'b0001) begin step(); n++; end
        checks++; if (bus.grant_o !== 4'b0001) begin errors++; $display("FAIL full_grant got %b want 0001", bus.grant_o); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.req_ready_o !== '0 || bus.add_o !== 1'b0 || bus.grant_o !== 4'b0001) begin
                errors++; $display("FAIL full_hold cyc %0d got ready=%b add=%b grant=%b want 0000/0/0001", i, bus.req_ready_o, bus.add_o, bus.grant_o);
            end
        end
        fullDrive = 1'b0;
        step();
        checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL full_resume_ready got %b want 0001", bus.req_ready_o); end
        step();
        checks++; if (bus.add_o !== 1'b1 || bus.data_o !== 8'h31) begin errors++; $display("FAIL full_resume_write got add=%b data=%h want 1/31", bus.add_o, bus.data_o); end
        drain(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout not drained within 100 cycles"); end
        checks++; if (logData.size() != 3) begin errors++; $display("FAIL full_count got %0d writes want 3", logData.size()); end
        for (int i = 0; i < 3 && i < logData.size(); i++) begin
            checks++; if (logData[i] !== 8'h31 + 8'(i)) begin errors++; $display("FAIL full_data %0d got %h want %h", i, logData[i], 8'h31 + 8'(i)); end
        end
    endtask

    task automatic test_packet_lock();
        int         expO [5] = '{0, 0, 0, 0, 3};
        logic [7:0] expD [5] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h3C};
        int n = 0;
        bit ok;
        apply_reset();
        enq(0, 8'h21, 1'b0); enq(0, 8'h22, 1'b0); enq(0, 8'h23, 1'b0); enq(0, 8'h24, 1'b1);
        enq(3, 8'h3C, 1'b1);
        while (n < 20 && logData.size() == 0) begin step(); n++; end
        checks++; if (logData.size() == 0) begin errors++; $display("FAIL lock_start no write within 20 cycles"); end
        gate[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.grant_o !== 4'b0001) begin errors++; $display("FAIL lock_hold cyc %0d got %b want 0001", i, bus.grant_o); end
        end
        gate[0] = 1'b0;
        drain(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lock_timeout not drained within 100 cycles"); end
        checks++; if (logData.size() != 5) begin errors++; $display("FAIL lock_count got %0d writes want 5", logData.size()); end
        for (int i = 0; i < 5 && i < logData.size(); i++) begin
            checks++; if (logOwner[i] != expO[i] || logData[i] !== expD[i]) begin
                errors++; $display("FAIL lock_order %0d got req%0d/%h want req%0d/%h", i, logOwner[i], logData[i], expO[i], expD[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit ok;
        apply_reset();
        enq(0, 8'h01, 1'b1);
        drain(50, ok);
        enq(1, 8'h11, 1'b0); enq(1, 8'h12, 1'b0); enq(1, 8'h13, 1'b1);
        while (n < 30 && logData.size() < 2) begin step(); n++; end
        checks++; if (logData.size() < 2) begin errors++; $display("FAIL rmid_start req1 not written within 30 cycles"); end
        @(posedge clk_s);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.grant_o !== '0 || bus.add_o !== 1'b0 || bus.data_o !== '0 || bus.req_ready_o !== '0 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL rmid_async got grant=%b add=%b data=%h ready=%b busy=%b want all zero",
                               bus.grant_o, bus.add_o, bus.data_o, bus.req_ready_o, bus.busy_o);
        end
        apply_reset();
        enq(1, 8'h14, 1'b1); enq(0, 8'h02, 1'b1);
        drain(50, ok);
        checks++; if (!ok || logData.size() != 2) begin errors++; $display("FAIL rmid_after got %0d writes ok=%0d want 2/1", logData.size(), ok); end
        if (logData.size() == 2) begin
            checks++; if (logOwner[0] != 0 || logData[0] !== 8'h02) begin errors++; $display("FAIL rmid_first got req%0d/%h want req0/02", logOwner[0], logData[0]); end
            checks++; if (logOwner[1] != 1 || logData[1] !== 8'h14) begin errors++; $display("FAIL rmid_second got req%0d/%h want req1/14", logOwner[1], logData[1]); end
        end
    endtask

    // Model: one owner at a time, a cooldown cycle after each write, release on last or burst cap.
    task automatic test_random();
        int mOwner, mPtr, mCount, pushed, len, cand;
        bit mCool, mRel, pF;
        logic [7:0] mData;
        logic [N-1:0] pV, pL, expGrant, expReady;
        logic [N*W-1:0] pD;
        apply_reset();
        mOwner = -1; mPtr = N - 1; mCount = 0; mCool = 0; mRel = 0; mData = '0; pushed = 0;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            if (cyc < 2600) begin
                for (int k = 0; k < N; k++) begin
                    if (dq[k].size() == 0 && $urandom_range(2, 0) == 0) begin
                        len = ($urandom_range(7, 0) == 0) ? int'($urandom_range(22, 17)) : int'($urandom_range(5, 1));
                        for (int b = 0; b < len; b++) enq(k, 8'($urandom), b == len - 1);
                        pushed += len;
                    end
                end
            end
            for (int k = 0; k < N; k++) gate[k] = ($urandom_range(3, 0) == 0);
            fullDrive = ($urandom_range(4, 0) == 0);
            pV = bus.req_valid_i; pL = bus.req_last_i; pD = bus.req_data_i; pF = bus.upFull_i;
            step();
            if (mCool) begin
                mCool = 1'b0;
                if (mRel) begin mPtr = mOwner; mOwner = -1; end
            end else if (mOwner < 0) begin
                for (int off = 1; off <= N; off++) begin
                    cand = (mPtr + off) % N;
                    if (pV[cand]) begin mOwner = cand; mCount = 0; break; end
                end
            end else if (pV[mOwner] && !pF) begin
                mCool  = 1'b1;
                mData  = pD[mOwner*W +: W];
                mCount = mCount + 1;
                mRel   = pL[mOwner] || (mCount == MB);
            end
            expGrant = (mOwner >= 0) ? (N'(1) << mOwner) : '0;
            expReady = (mOwner >= 0 && !mCool && !bus.upFull_i) ? (bus.req_valid_i & expGrant) : '0;
            checks++; if (bus.grant_o !== expGrant) begin errors++; $display("FAIL rand_grant cyc %0d got %b want %b", cyc, bus.grant_o, expGrant); end
            checks++; if (bus.add_o !== mCool) begin errors++; $display("FAIL rand_add cyc %0d got %b want %b", cyc, bus.add_o, mCool); end
            checks++; if (bus.data_o !== mData) begin errors++; $display("FAIL rand_data cyc %0d got %h want %h", cyc, bus.data_o, mData); end
            checks++; if (bus.busy_o !== (mOwner >= 0)) begin errors++; $display("FAIL rand_busy cyc %0d got %b want %b", cyc, bus.busy_o, mOwner >= 0); end
            checks++; if (bus.req_ready_o !== expReady) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, bus.req_ready_o, expReady); end
        end
        checks++; if (!allEmpty() || logData.size() != pushed) begin
            errors++; $display("FAIL rand_total got %0d writes (queues empty=%0d) want %0d", logData.size(), allEmpty(), pushed);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        popped = 0;
        cycNum = 0;
        fullDrive = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_burst_limit();
        test_upfull();
        test_packet_lock();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
